// File: rtl/div_mem_pkg.sv
// Shared types and size helpers for the scratch-memory divider lane sequencer.
package div_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WRITE     = 2'd2,
    GAP       = 2'd3
  } state_t;

  function automatic int num_div(input int lanes_per_line, input int num_lines);
    return lanes_per_line * num_lines;
  endfunction

  function automatic int line_w(input int lanes_per_line, input int data_w);
    return lanes_per_line * data_w;
  endfunction

  function automatic int addr_w(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  // Gap counter must hold WT_GAP-1; width stays at least one bit when the gap is zero.
  function automatic int gap_w(input int wt_gap);
    return (wt_gap > 1) ? $clog2(wt_gap) : 1;
  endfunction

endpackage

// File: rtl/div_lane_capture.sv
// One divider lane: sticky done flag plus result snapshot, taken on the first sampled done.
// Snapshot visible one cycle after the sampled done; clear dominates and has no backpressure.
module div_lane_capture #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_sample_en,
  input  logic              i_done,
  input  logic [DATA_W-1:0] i_value,
  output logic              o_done_seen,
  output logic [DATA_W-1:0] o_value
);

  logic              r_seen;
  logic [DATA_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_seen  <= 1'b0;
      r_value <= '0;
    end else if (i_sample_en && i_done && !r_seen) begin
      r_seen  <= 1'b1;
      r_value <= i_value;
    end
  end

  assign o_done_seen = r_seen;
  assign o_value     = r_value;

endmodule

// File: rtl/div_lane_mem_sequencer.sv
// Fans scratch-memory lines out to divider lanes, gathers results, writes them back line by line.
// First write one cycle after the final done; later reads while busy are dropped and flag overrun.
module div_lane_mem_sequencer
  import div_mem_pkg::*;
#(
  parameter  int DATA_W         = 32,
  parameter  int LANES_PER_LINE = 4,
  parameter  int NUM_LINES      = 2,
  parameter  int WT_GAP         = 2,
  localparam int NUM_DIV        = num_div(LANES_PER_LINE, NUM_LINES),
  localparam int LINE_W         = line_w(LANES_PER_LINE, DATA_W),
  localparam int ADDR_W         = addr_w(NUM_LINES),
  localparam int GAP_W          = gap_w(WT_GAP)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sc_mem_rd_data_rdy,
  input  logic [NUM_LINES*LINE_W-1:0] sc_mem_rd_data,
  input  logic [NUM_DIV-1:0]          div_done,
  input  logic [NUM_DIV*DATA_W-1:0]   div_value,
  output logic [NUM_DIV*DATA_W-1:0]   cdfval_todiv,
  output logic                        div_start,
  output logic                        sc_mem_wt_en,
  output logic [ADDR_W-1:0]           sc_mem_wt_addr,
  output logic [LINE_W-1:0]           sc_mem_wt_data,
  output logic                        busy,
  output logic                        overrun
);

  state_t                     r_state;
  logic [ADDR_W-1:0]          r_line;
  logic [GAP_W-1:0]           r_gap_cnt;
  logic                       r_busy;

  logic                       w_accept;
  logic                       w_sample;
  logic                       w_all_done;
  logic                       w_last_line;
  logic [ADDR_W-1:0]          w_line_inc;
  logic [NUM_DIV-1:0]         w_seen;
  logic [NUM_DIV*DATA_W-1:0]  w_snap;
  logic [NUM_DIV*DATA_W-1:0]  w_snap_nxt;

  assign w_accept    = (r_state == IDLE) && enable && sc_mem_rd_data_rdy;
  // The div_start cycle is excluded so a stale done from the previous job cannot count.
  assign w_sample    = (r_state == WAIT_DONE) && !div_start;
  assign w_all_done  = &(w_seen | (div_done & {NUM_DIV{w_sample}}));
  assign w_last_line = (r_line == ADDR_W'(NUM_LINES - 1));
  assign w_line_inc  = r_line + 1'b1;

  for (genvar k = 0; k < NUM_DIV; k++) begin : g_lane
    div_lane_capture #(
      .DATA_W(DATA_W)
    ) u_cap (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_accept),
      .i_sample_en (w_sample),
      .i_done      (div_done[k]),
      .i_value     (div_value[k*DATA_W +: DATA_W]),
      .o_done_seen (w_seen[k]),
      .o_value     (w_snap[k*DATA_W +: DATA_W])
    );
    // Line 0 is written on the same edge the last lanes capture, so bypass their snapshot.
    assign w_snap_nxt[k*DATA_W +: DATA_W] = w_seen[k] ? w_snap[k*DATA_W +: DATA_W]
                                                      : div_value[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_line         <= '0;
      r_gap_cnt      <= '0;
      r_busy         <= 1'b0;
      cdfval_todiv   <= '0;
      div_start      <= 1'b0;
      sc_mem_wt_en   <= 1'b0;
      sc_mem_wt_data <= '0;
      overrun        <= 1'b0;
    end else begin
      div_start <= 1'b0;
      if (sc_mem_rd_data_rdy && r_busy) overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            cdfval_todiv <= sc_mem_rd_data;
            div_start    <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (w_all_done) begin
            r_line         <= '0;
            sc_mem_wt_en   <= 1'b1;
            sc_mem_wt_data <= w_snap_nxt[LINE_W-1:0];
            r_state        <= WRITE;
          end
        end

        WRITE: begin
          sc_mem_wt_en   <= 1'b0;
          sc_mem_wt_data <= '0;
          if (WT_GAP > 0) begin
            r_gap_cnt <= GAP_W'(WT_GAP - 1);
            r_state   <= GAP;
          end else if (w_last_line) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_line         <= w_line_inc;
            sc_mem_wt_en   <= 1'b1;
            sc_mem_wt_data <= w_snap[w_line_inc*LINE_W +: LINE_W];
            r_state        <= WRITE;
          end
        end

        GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end else if (w_last_line) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_line         <= w_line_inc;
            sc_mem_wt_en   <= 1'b1;
            sc_mem_wt_data <= w_snap[w_line_inc*LINE_W +: LINE_W];
            r_state        <= WRITE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign sc_mem_wt_addr = r_line;
  assign busy           = r_busy;

endmodule
